cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter WORDS, default 8, means the number of 16-bit words per cache block; legal values are powers of two from 2 to 16.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-004 Port miss_detected, input, 1 bit: the cache reports a miss on miss_address this cycle.
REQ-005 Port miss_address, input, 16 bits: byte address that missed.
REQ-006 Port memory_data, input, 16 bits: read data returned by main memory.
REQ-007 Port memory_data_valid, input, 1 bit: memory_data holds one returned word this cycle.
REQ-008 Port fsm_busy, output, 1 bit: a fill is in progress; the pipeline stalls on it.
REQ-009 Port memory_read, output, 1 bit: issue a read to memory at memory_address this cycle.
REQ-010 Port memory_address, output, 16 bits: byte address of the current read request.
REQ-011 Port write_data_array, output, 1 bit: write fill_data into the data array at word_index.
REQ-012 Port word_index, output, clog2(WORDS) bits: word slot being written within the block.
REQ-013 Port fill_data, output, 16 bits: data to write, a direct pass-through of memory_data.
REQ-014 Port write_tag_array, output, 1 bit: write the tag for fill_base; this marks the block valid.
REQ-015 Port fill_base, output, 16 bits: block-aligned base address of the current fill.

Function
REQ-016 The block SHALL have two states, IDLE and FILL, held in a state register.
REQ-017 In IDLE, a high miss_detected SHALL cause three updates at the next edge: latch base = miss_address with its low clog2(2*WORDS) bits cleared, clear both counters, and enter FILL.
REQ-018 fsm_busy SHALL equal (state == FILL); it is registered, so it rises one cycle after the miss is sampled.
REQ-019 In FILL, memory_read SHALL be 1 while issue_cnt < WORDS, with memory_address = base + 2*issue_cnt, and issue_cnt SHALL increment by 1 each such cycle.
REQ-020 memory_read SHALL be 0 when issue_cnt = WORDS; issue_cnt SHALL saturate at WORDS, for exactly WORDS requests per fill issued on consecutive cycles.
REQ-021 When memory_read = 0, memory_address SHALL be 16'h0000.
REQ-022 In FILL with memory_data_valid = 1, in the same cycle: write_data_array = 1, word_index = recv_cnt, fill_data = memory_data, and recv_cnt SHALL increment at the edge.
REQ-023 Returned data SHALL be accepted in any cycle of FILL, including cycles that still issue requests; the issue and receive counters SHALL be independent.
REQ-024 A valid word with recv_cnt = WORDS-1 SHALL also assert write_tag_array in that cycle, and the state SHALL return to IDLE at the next edge.
REQ-025 memory_data_valid in IDLE SHALL be ignored: no array writes and no counter change.
REQ-026 miss_detected during FILL SHALL be ignored; the cache re-presents the miss after fsm_busy falls.
REQ-027 A miss sampled in the first IDLE cycle after a fill SHALL start a new fill with no extra gap.
REQ-028 fill_base SHALL output the latched base and hold it from fill start until the next fill starts.
REQ-029 write_data_array and write_tag_array SHALL be 0 in every cycle not covered by REQ-022 and REQ-024.

Reset
REQ-030 rst = 1 SHALL at the next edge set the state to IDLE, clear issue_cnt, recv_cnt and base, and hold all outputs at 0.
REQ-031 rst asserted mid-fill SHALL abort the fill: no write_tag_array, and data returning after reset is ignored per REQ-025.

Verification
REQ-032 Basic fill: miss 0x1236 sampled at cycle 0, memory latency 4, WORDS = 8 -> expected response:
  - cycles 1-8: memory_read = 1 at addresses 0x1230, 0x1232, ... 0x123E;
  - cycles 5-12: data writes to word_index 0-7;
  - cycle 12: write_tag_array = 1 with fill_base = 0x1230;
  - fsm_busy = 1 for cycles 1-12 and 0 at cycle 13.
REQ-033 Gapped returns: memory_data_valid pulses with 2-cycle gaps -> word_index increments only on valid pulses; exactly 8 data writes and 1 tag write per fill.
REQ-034 Back-to-back misses: a second miss 0xFFF0 sampled at cycle 13 -> requests 0xFFF0 through 0xFFFE from cycle 14; a miss held during the first fill is ignored.
REQ-035 Reset mid-fill: rst at cycle 6, then the remaining valids -> no writes after reset, fsm_busy = 0 and memory_read = 0 from cycle 7.
REQ-036 Idle noise: memory_data_valid toggling with no miss -> write_data_array = 0 and write_tag_array = 0 throughout.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
//   Refills one cache block after a miss. The block-aligned base of the
//   missing address is latched, WORDS consecutive 16-bit reads are issued to
//   main memory on back-to-back cycles, and returned words are streamed into
//   the data array as they arrive. The tag is written together with the last
//   data word, which marks the block valid and ends the fill.
//
// Ports
//   clk               : clock, all state changes on its rising edge
//   rst               : synchronous active-high reset
//   miss_detected     : cache reports a miss on miss_address this cycle
//   miss_address      : byte address that missed
//   memory_data       : read data returned by main memory
//   memory_data_valid : memory_data holds one returned word this cycle
//   fsm_busy          : fill in progress (registered state decode)
//   memory_read       : issue a memory read at memory_address this cycle
//   memory_address    : byte address of the current read, 0 when idle
//   write_data_array  : write fill_data into the data array at word_index
//   word_index        : word slot within the block being written
//   fill_data         : pass-through of memory_data
//   write_tag_array   : write the tag for fill_base (block becomes valid)
//   fill_base         : block-aligned base address of the current fill
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_detected,
  input  logic [15:0]                miss_address,
  input  logic [15:0]                memory_data,
  input  logic                       memory_data_valid,
  output logic                       fsm_busy,
  output logic                       memory_read,
  output logic [15:0]                memory_address,
  output logic                       write_data_array,
  output logic [$clog2(WORDS)-1:0]   word_index,
  output logic [15:0]                fill_data,
  output logic                       write_tag_array,
  output logic [15:0]                fill_base
);

  localparam int IDX_W = $clog2(WORDS);
  // issue_cnt needs one extra bit so it can saturate at WORDS
  localparam int CNT_W = IDX_W + 1;
  // A block spans WORDS * 2 bytes, so this many address bits are the offset
  localparam int OFF_W = $clog2(2 * WORDS);

  localparam logic [15:0]      BASE_MASK  = 16'hFFFF << OFF_W;
  localparam logic [CNT_W-1:0] ISSUE_MAX  = CNT_W'(WORDS);
  localparam logic [IDX_W-1:0] RECV_LAST  = IDX_W'(WORDS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0] recv_cnt_q, recv_cnt_d;
  logic [15:0]      issue_off_s;

  // Byte offset of the next request: two bytes per word
  assign issue_off_s = 16'(issue_cnt_q) << 1;

  assign fsm_busy  = (state_q == FILL);
  assign fill_base = base_q;
  assign fill_data = memory_data;

  // Next-state, counter and request/write strobe logic
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    memory_read      = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;

    // While reset is held no request or array write may escape, even if
    // the registered state still says FILL during this cycle.
    if (rst) begin
      state_d     = IDLE;
      base_d      = 16'h0000;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Returned data while idle is ignored entirely
          if (miss_detected) begin
            base_d      = miss_address & BASE_MASK;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            state_d     = FILL;
          end else begin
            state_d = IDLE;
          end
        end
        FILL: begin
          // Request side: one read per cycle until WORDS have been issued
          if (issue_cnt_q < ISSUE_MAX) begin
            memory_read    = 1'b1;
            memory_address = base_q + issue_off_s;
            issue_cnt_d    = issue_cnt_q + CNT_W'(1);
          end else begin
            memory_read = 1'b0;
          end

          // Receive side runs independently of the request side
          if (memory_data_valid) begin
            write_data_array = 1'b1;
            word_index       = recv_cnt_q;
            recv_cnt_d       = recv_cnt_q + IDX_W'(1);
            if (recv_cnt_q == RECV_LAST) begin
              write_tag_array = 1'b1;
              state_d         = IDLE;
            end else begin
              state_d = FILL;
            end
          end else begin
            write_data_array = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, base and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= 16'h0000;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_fsm
//   Directed bench for cache_fill_fsm with WORDS = 8. Inputs change on the
//   falling clock edge and outputs are checked 1 ns later, so every cycle
//   number below refers to the interval that ends at the next rising edge.
// ---------------------------------------------------------------------------
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] fill_base;

  int tests = 0;
  int fails = 0;

  cache_fill_fsm #(.WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_base         (fill_base)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and settle before checking
  task automatic drive(input logic r, input logic m, input logic [15:0] ma,
                       input logic v, input logic [15:0] d);
    @(negedge clk);
    rst               = r;
    miss_detected     = m;
    miss_address      = ma;
    memory_data_valid = v;
    memory_data       = d;
    #1;
  endtask

  initial begin
    int wcnt;
    int tcnt;
    logic        v;
    logic [15:0] d;

    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000;
    memory_data = 16'h0000; memory_data_valid = 1'b0;

    // Reset state
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("rst busy",  {31'd0, fsm_busy},         32'd0);
    chk("rst read",  {31'd0, memory_read},      32'd0);
    chk("rst addr",  {16'd0, memory_address},   32'd0);
    chk("rst wda",   {31'd0, write_data_array}, 32'd0);
    chk("rst wta",   {31'd0, write_tag_array},  32'd0);
    chk("rst base",  {16'd0, fill_base},        32'd0);

    // Fill A: miss 0x1236 at cycle 0, latency 4; a miss on 0x5550 is held
    // through the fill and must be ignored; miss 0xFFF0 arrives at cycle 13.
    drive(1'b0, 1'b1, 16'h1236, 1'b0, 16'h0000);
    chk("A c0 busy", {31'd0, fsm_busy},    32'd0);
    chk("A c0 read", {31'd0, memory_read}, 32'd0);
    for (int c = 1; c <= 13; c++) begin
      v = (c >= 5) && (c <= 12);
      d = 16'hA000 + 16'(c);
      if (c == 13) drive(1'b0, 1'b1, 16'hFFF0, v, d);
      else         drive(1'b0, 1'b1, 16'h5550, v, d);
      chk($sformatf("A c%0d busy", c), {31'd0, fsm_busy}, {31'd0, (c <= 12)});
      chk($sformatf("A c%0d read", c), {31'd0, memory_read}, {31'd0, (c <= 8)});
      chk($sformatf("A c%0d addr", c), {16'd0, memory_address},
          (c <= 8) ? 32'h1230 + 32'(2 * (c - 1)) : 32'd0);
      chk($sformatf("A c%0d wda", c), {31'd0, write_data_array}, {31'd0, v});
      chk($sformatf("A c%0d wta", c), {31'd0, write_tag_array}, {31'd0, (c == 12)});
      chk($sformatf("A c%0d base", c), {16'd0, fill_base}, 32'h1230);
      if (v) begin
        chk($sformatf("A c%0d idx", c), {29'd0, word_index}, 32'(c - 5));
        chk($sformatf("A c%0d data", c), {16'd0, fill_data}, {16'd0, d});
      end
    end

    // Fill B: starts at cycle 14 with no gap; returns every third cycle
    wcnt = 0;
    tcnt = 0;
    for (int c = 14; c <= 40; c++) begin
      v = (c >= 18) && (c <= 39) && (((c - 18) % 3) == 0);
      d = 16'hB000 + 16'(c);
      drive(1'b0, 1'b0, 16'h0000, v, d);
      if (write_data_array) wcnt++;
      if (write_tag_array)  tcnt++;
      chk($sformatf("B c%0d busy", c), {31'd0, fsm_busy}, {31'd0, (c <= 39)});
      chk($sformatf("B c%0d read", c), {31'd0, memory_read}, {31'd0, (c <= 21)});
      chk($sformatf("B c%0d addr", c), {16'd0, memory_address},
          (c <= 21) ? 32'hFFF0 + 32'(2 * (c - 14)) : 32'd0);
      chk($sformatf("B c%0d wta", c), {31'd0, write_tag_array}, {31'd0, (c == 39)});
      chk($sformatf("B c%0d base", c), {16'd0, fill_base}, 32'hFFF0);
      if (v) chk($sformatf("B c%0d idx", c), {29'd0, word_index}, 32'((c - 18) / 3));
    end
    chk("B writes", 32'(wcnt), 32'd8);
    chk("B tags",   32'(tcnt), 32'd1);

    // Idle noise: toggling valid with no miss writes nothing
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 16'h0000, c[0], 16'hC000 + 16'(c));
      chk($sformatf("N c%0d wda", c),  {31'd0, write_data_array}, 32'd0);
      chk($sformatf("N c%0d wta", c),  {31'd0, write_tag_array},  32'd0);
      chk($sformatf("N c%0d busy", c), {31'd0, fsm_busy},         32'd0);
      chk($sformatf("N c%0d read", c), {31'd0, memory_read},      32'd0);
    end

    // Reset mid-fill: miss 0x1236 at cycle 0, rst at cycle 6, valids to 12
    drive(1'b0, 1'b1, 16'h1236, 1'b0, 16'h0000);
    for (int c = 1; c <= 15; c++) begin
      v = (c >= 5) && (c <= 12);
      drive((c == 6), 1'b0, 16'h0000, v, 16'hD000 + 16'(c));
      if (c == 5) chk("R c5 wda", {31'd0, write_data_array}, 32'd1);
      if (c >= 7) begin
        chk($sformatf("R c%0d busy", c), {31'd0, fsm_busy},         32'd0);
        chk($sformatf("R c%0d read", c), {31'd0, memory_read},      32'd0);
        chk($sformatf("R c%0d wda", c),  {31'd0, write_data_array}, 32'd0);
        chk($sformatf("R c%0d wta", c),  {31'd0, write_tag_array},  32'd0);
        chk($sformatf("R c%0d base", c), {16'd0, fill_base},        32'd0);
      end
    end

    // Recovery: a fresh miss after reset aligns and issues normally
    drive(1'b0, 1'b1, 16'h004F, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("Q busy", {31'd0, fsm_busy},       32'd1);
    chk("Q read", {31'd0, memory_read},    32'd1);
    chk("Q addr", {16'd0, memory_address}, 32'h0040);
    chk("Q base", {16'd0, fill_base},      32'h0040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
